cpu_sequencer: RTL and testbench

- Multi-cycle sequencer for the single-issue core.
- Steps each instruction through fetch, decode, execute, optional memory and writeback, and gates the decoder's write strobes into single-cycle enables.
- Stalls on variable-latency data memory, with a timeout.
- Provides the start/done handshake to the testbench or host, plus cycle and instruction counters.

---
 rtl/cpu_seq_pkg.sv | 17 +
 rtl/cpu_sequencer_mem_wait_timer.sv | 32 +++
 rtl/cpu_sequencer.sv | 122 ++++++++++++
 tb/tb_cpu_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the multi-cycle instruction sequencer.
package cpu_seq_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Up-counter for cycles spent waiting on data memory. It is held at zero while
// clear is high and flags the last permitted wait cycle on terminal.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

  // The count equals LIMIT-1 during the LIMIT-th wait cycle.
  assign terminal = (count == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/[MEM]/WB with a memory-wait timeout,
// a start/done host handshake and saturating cycle/instruction counters.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             RegWrite,
  input  logic             ReadMem,
  input  logic             MemWrite,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  seq_state_t state;
  seq_state_t next_state;
  logic       wait_tc;
  logic       launch;
  logic       mem_timeout;

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != S_MEM),
    .inc     ((state == S_MEM) && !mem_ready),
    .terminal(wait_tc)
  );

  assign launch      = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign mem_timeout = (state == S_MEM) && !mem_ready && wait_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        ir_load    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = halt ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        next_state = (ReadMem || MemWrite) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // A read takes precedence if the decoder ever flags both accesses.
        mem_re = ReadMem;
        mem_we = MemWrite && !ReadMem;
        if (mem_ready)    next_state = S_WB;
        else if (wait_tc) next_state = S_DONE;
      end
      S_WB: begin
        pc_en      = 1'b1;
        reg_we     = RegWrite;
        next_state = S_FETCH;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) next_state = S_FETCH;
      end
      default: begin
        busy       = 1'b0;
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
      err         <= 1'b0;
    end else if (launch) begin
      cycle_count <= '0;
      instr_count <= '0;
      err         <= 1'b0;
    end else begin
      if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
      if ((state == S_WB) && (instr_count != '1)) instr_count <= instr_count + 1'b1;
      if (mem_timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs push expected strobe
// events; a negedge monitor pops and compares each event the DUT presents.
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic        ir_load;
    logic        pc_en;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] ic;
    logic [15:0] cc;
  } ev_t;

  typedef struct {
    logic halt;
    logic rw;
    logic rd;
    logic wr;
    int   lat;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        RegWrite = 1'b0;
  logic        ReadMem = 1'b0;
  logic        MemWrite = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_en, reg_we, mem_re, mem_we, busy, done, err;
  logic [15:0] cycle_count, instr_count;

  int     vectors = 0;
  int     miscompares = 0;
  int     mem_lat = 0;
  int     mcnt = 0;
  logic   done_q = 1'b0;
  ev_t    exp_q[$];
  instr_t prog[$];

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CNT_W      (16),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .RegWrite   (RegWrite),
    .ReadMem    (ReadMem),
    .MemWrite   (MemWrite),
    .mem_ready  (mem_ready),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .reg_we     (reg_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic ir, input logic pc, input logic rw, input logic re,
                             input logic we, input logic bz, input logic dn, input logic er,
                             input int ic, input int cc);
    return {ir, pc, rw, re, we, bz, dn, er, 16'(ic), 16'(cc)};
  endfunction

  function automatic ev_t observed();
    return {ir_load, pc_en, reg_we, mem_re, mem_we, busy, done, err, instr_count, cycle_count};
  endfunction

  // Expected event stream for prog, with counters starting from a fresh start.
  task automatic push_run();
    int   cc;
    int   ic;
    int   n;
    logic timeout;
    cc = 0;
    ic = 0;
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, ic, cc));
      if (prog[i].halt) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, ic, cc + 2));
        return;
      end
      cc += 3;
      if (prog[i].rd || prog[i].wr) begin
        timeout = (prog[i].lat == 0) || (prog[i].lat > MEM_TIMEOUT);
        n = timeout ? MEM_TIMEOUT : prog[i].lat;
        for (int j = 0; j < n; j++)
          exp_q.push_back(mk(0, 0, 0, prog[i].rd, prog[i].wr && !prog[i].rd, 1, 0, 0, ic, cc + j));
        cc += n;
        if (timeout) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, ic, cc));
          return;
        end
      end
      exp_q.push_back(mk(0, 1, prog[i].rw, 0, 0, 1, 0, 0, ic, cc));
      cc++;
      ic++;
    end
  endtask

  // Waits for the FETCH of the next instruction, then presents its decode.
  task automatic drive_instr(input instr_t ins);
    int k;
    for (k = 0; k < 100; k++) begin
      if (ir_load) break;
      @(posedge clk);
      #1;
    end
    if (k == 100) begin
      vectors++;
      miscompares++;
      $display("FAIL fetch_wait: ir_load low for 100 cycles, required high");
    end
    halt     = ins.halt;
    RegWrite = ins.rw;
    ReadMem  = ins.rd;
    MemWrite = ins.wr;
    mem_lat  = ins.lat;
    @(posedge clk);
    #1;
  endtask

  task automatic run_prog();
    for (int i = 0; i < prog.size(); i++) drive_instr(prog[i]);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    if (k == 400) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_done_wait: done low for 400 cycles, required high", name);
    end
    @(negedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  function automatic instr_t ins(input logic h, input logic rw, input logic rd,
                                 input logic wr, input int lat);
    instr_t t;
    t.halt = h;
    t.rw   = rw;
    t.rd   = rd;
    t.wr   = wr;
    t.lat  = lat;
    return t;
  endfunction

  // Data memory responder: ready in the mem_lat-th strobe cycle (0 = never).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_re || mem_we) begin
        mcnt++;
        mem_ready = (mem_lat != 0) && (mcnt == mem_lat);
      end else begin
        mcnt      = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: any strobe, or the rising edge of done, is one event.
  initial begin
    ev_t got;
    ev_t want;
    forever begin
      @(negedge clk);
      if (rst_n && (ir_load || pc_en || reg_we || mem_re || mem_we || (done && !done_q))) begin
        got = observed();
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got %h, expected no event", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            miscompares++;
            $display("FAIL event: got %h, expected %h", got, want);
          end
        end
      end
      done_q = done;
    end
  end

  initial begin
    // Reset held three cycles: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", observed(), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_outputs", observed(), 0);

    // ALU op with RegWrite, then halt.
    prog = '{ins(0, 1, 0, 0, 0), ins(1, 0, 0, 0, 0)};
    push_run();
    start_pulse();
    check("start_busy", busy, 1);
    run_prog();
    wait_done("alu_halt");
    check("alu_instr_count", instr_count, 1);
    check("alu_cycle_count", cycle_count, 6);

    // Load, ready in the third MEM cycle, then halt.
    prog = '{ins(0, 1, 1, 0, 3), ins(1, 0, 0, 0, 0)};
    push_run();
    start_pulse();
    run_prog();
    wait_done("load");
    check("load_cycle_count", cycle_count, 9);

    // Store with no ready: timeout.
    prog = '{ins(0, 0, 0, 1, 0)};
    push_run();
    start_pulse();
    run_prog();
    wait_done("store_timeout");
    check("timeout_err", err, 1);
    check("timeout_done", done, 1);

    // A new start clears err.
    prog = '{ins(0, 1, 0, 0, 0), ins(1, 0, 0, 0, 0)};
    push_run();
    start_pulse();
    check("restart_err_clear", err, 0);
    run_prog();
    wait_done("after_timeout");

    // Reset during a store's MEM phase.
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    start_pulse();
    drive_instr(ins(0, 0, 0, 1, 0));
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (mem_we) break;
        @(posedge clk);
        #1;
      end
      check("mid_mem_we_seen", mem_we, 1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", observed(), 0);
    MemWrite = 1'b0;
    mem_lat  = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle", observed(), 0);
    check("abort_drain", exp_q.size(), 0);

    // Start held through DONE: immediate restart, start ignored while busy.
    prog = '{ins(0, 1, 0, 0, 0), ins(1, 0, 0, 0, 0)};
    push_run();
    push_run();
    start = 1'b1;
    drive_instr(prog[0]);
    drive_instr(prog[1]);
    drive_instr(prog[0]);
    start = 1'b0;
    drive_instr(prog[1]);
    wait_done("start_held");
    check("held_instr_count", instr_count, 1);
    check("held_cycle_count", cycle_count, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
